// File: rtl/layer_sequencer.sv
// Layer descriptor table and per-layer kick/wait/advance sequencer for the conv controller.
// Walks the table from slot 0, validating each descriptor before it is kicked.
module layer_sequencer #(
  parameter int MAX_LAYERS     = 4,
  parameter int LIDX_W         = 2,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TO_W           = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [LIDX_W-1:0] cfg_addr,
  input  logic [47:0]       cfg_data,
  input  logic [LIDX_W:0]   num_layers,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LIDX_W-1:0] layer_idx,
  output logic              ctrl_enable,
  output logic [7:0]        size_act,
  output logic [7:0]        size_kernel,
  output logic [7:0]        stride,
  output logic [7:0]        number_pc_line,
  output logic [15:0]       address_read_base,
  input  logic              ctrl_endsignal
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_RUN, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t            state;
  logic [47:0]       table_q [MAX_LAYERS];
  logic [LIDX_W:0]   num_q;
  logic [TO_W-1:0]   watchdog;
  logic [47:0]       cur;

  assign cur         = table_q[layer_idx];
  assign ctrl_enable = (state == S_KICK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      for (int unsigned i = 0; i < int'(MAX_LAYERS); i++) table_q[i] <= '0;
      num_q             <= '0;
      watchdog          <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      layer_idx         <= '0;
      size_act          <= '0;
      size_kernel       <= '0;
      stride            <= '0;
      number_pc_line    <= '0;
      address_read_base <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cfg_we) table_q[cfg_addr] <= cfg_data;
          if (start) begin
            busy <= 1'b1;
            if (num_layers > (LIDX_W+1)'(MAX_LAYERS)) begin
              state <= S_ERR;
            end else if (num_layers == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              num_q     <= num_layers;
              layer_idx <= '0;
              error     <= 1'b0;
              state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          {size_act, size_kernel, stride, number_pc_line, address_read_base} <= cur;
          if (cur[31:24] == '0 || cur[39:32] == '0 || cur[39:32] > cur[47:40])
            state <= S_ERR;
          else
            state <= S_KICK;
        end
        S_KICK: begin
          watchdog <= '0;
          state    <= S_RUN;
        end
        S_RUN: begin
          // End pulse takes priority over a watchdog expiry in the same cycle.
          if (ctrl_endsignal)
            state <= S_NEXT;
          else if (watchdog == TO_W'(TIMEOUT_CYCLES - 1))
            state <= S_ERR;
          else
            watchdog <= watchdog + 1'b1;
        end
        S_NEXT: begin
          if ({1'b0, layer_idx} + 1'b1 == num_q) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            layer_idx <= layer_idx + 1'b1;
            state     <= S_LOAD;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: a run planner predicts kicks and outcomes from the
// descriptor rules, and a negedge monitor pops and compares them as the DUT presents them.
module tb_layer_sequencer;

  localparam int TO   = 16;
  localparam int MAXL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [47:0] cfg_data = '0;
  logic [2:0]  num_layers = '0;
  logic        start = 1'b0;
  logic        ctrl_endsignal = 1'b0;
  logic        busy, done, error, ctrl_enable;
  logic [1:0]  layer_idx;
  logic [7:0]  size_act, size_kernel, stride, number_pc_line;
  logic [15:0] address_read_base;

  layer_sequencer #(
    .MAX_LAYERS(MAXL), .LIDX_W(2), .TIMEOUT_CYCLES(TO), .TO_W(20)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .num_layers(num_layers), .start(start), .busy(busy), .done(done), .error(error),
    .layer_idx(layer_idx), .ctrl_enable(ctrl_enable), .size_act(size_act),
    .size_kernel(size_kernel), .stride(stride), .number_pc_line(number_pc_line),
    .address_read_base(address_read_base), .ctrl_endsignal(ctrl_endsignal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [49:0] exp_kick [$];   // {layer_idx, descriptor}
  logic [1:0]  exp_out  [$];   // {done seen during run, error after run}
  logic [47:0] tbl [MAXL];
  logic        err_m = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [47:0] mk(input int a, input int k, input int s, input int p, input int b);
    return {8'(a), 8'(k), 8'(s), 8'(p), 16'(b)};
  endfunction

  function automatic bit desc_ok(input logic [47:0] d);
    return d[31:24] != 0 && d[39:32] != 0 && d[39:32] <= d[47:40];
  endfunction

  function automatic logic [47:0] rand_desc();
    int a, k, s;
    a = $urandom_range(1, 255);
    k = $urandom_range(1, a);
    if ($urandom_range(0, 9) == 0) k = 0;
    if ($urandom_range(0, 9) == 0 && a < 255) k = a + 1;
    s = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
    return mk(a, k, s, $urandom_range(0, 255), $urandom_range(0, 65535));
  endfunction

  task automatic write_cfg(input int a, input logic [47:0] d);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_data = d;
    tick();
    cfg_we = 1'b0;
    tbl[a] = d;
  endtask

  // dly=0 picks a random end delay per layer; rst_layer>=0 resets during that layer's RUN.
  task automatic do_run(input int n, input int dly, input int rst_layer);
    int dq [$];
    bit lastq [$];
    bit ok, fk, cur_last, finished;
    int dl, cnt, end_tick, kcount, rcnt;
    logic [47:0] d;
    fk = 0;
    if (n > MAXL) begin
      err_m = 1'b1; exp_out.push_back(2'b01);
    end else if (n == 0) begin
      exp_out.push_back({1'b1, err_m});
    end else begin
      err_m = 1'b0; ok = 1;
      for (int i = 0; i < n; i++) begin
        d = tbl[i];
        if (!desc_ok(d)) begin err_m = 1'b1; exp_out.push_back(2'b01); ok = 0; break; end
        exp_kick.push_back({2'(i), d});
        if (i == 0) fk = 1;
        dl = (dly != 0) ? dly : $urandom_range(1, TO + 2);
        dq.push_back(dl);
        lastq.push_back(i == n - 1);
        if (dl > TO) begin err_m = 1'b1; exp_out.push_back(2'b01); ok = 0; break; end
      end
      if (ok) exp_out.push_back(2'b10);
    end

    start = 1'b1; num_layers = 3'(n);
    cnt = 0; end_tick = -1; kcount = 0; rcnt = -1; cur_last = 0; finished = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      start = 1'b0; cfg_we = 1'b0; ctrl_endsignal = 1'b0;
      if (c == 0) check("busy_after_start", busy, 1);
      if (c == 1) check("kick_latency", ctrl_enable, fk);
      if (ctrl_enable) begin
        cnt = (dq.size() > 0) ? dq.pop_front() : 0;
        cur_last = (lastq.size() > 0) ? lastq.pop_front() : 0;
        if (kcount == rst_layer) rcnt = 4;
        kcount++;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ctrl_endsignal = 1'b1;
          if (cur_last) end_tick = c;
        end
      end
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          rst = 1'b1; ctrl_endsignal = 1'b0;
          exp_kick.delete(); exp_out.delete();
          tick();
          check("reset_mid_run", {busy, done, error, layer_idx, ctrl_enable, size_act,
                size_kernel, stride, number_pc_line, address_read_base}, 0);
          tick();
          rst = 1'b0;
          for (int j = 0; j < MAXL; j++) tbl[j] = '0;
          err_m = 1'b0;
          finished = 1;
          break;
        end
      end
      if (done && end_tick >= 0) check("done_latency", c - end_tick, 2);
      if (c > 0 && !busy) begin finished = 1; break; end
      if (busy && $urandom_range(0, 7) == 0) begin
        cfg_we = 1'b1; cfg_addr = 2'($urandom_range(0, 3)); cfg_data = {$urandom, $urandom};
      end
      if (busy && $urandom_range(0, 5) == 0) begin
        start = 1'b1; num_layers = 3'($urandom_range(0, 7));
      end
    end
    check("run_finished", finished, 1);
    tick(); tick();
  endtask

  // Monitor: sampled on the falling edge, when both DUT outputs and bench inputs are settled.
  initial begin : monitor
    logic        prev_busy, prev_en, prev_done, running, done_seen;
    logic [47:0] kick_cfg, cfg_now;
    logic [49:0] ek;
    logic [1:0]  eo;
    prev_busy = 0; prev_en = 0; prev_done = 0; running = 0; done_seen = 0; kick_cfg = '0;
    forever begin
      @(negedge clk);
      cfg_now = {size_act, size_kernel, stride, number_pc_line, address_read_base};
      if (rst) begin
        prev_busy = 0; prev_en = 0; prev_done = 0; running = 0; done_seen = 0;
        continue;
      end
      if (ctrl_enable) begin
        check("enable_single", prev_en, 0);
        check("error_cleared", error, 0);
        if (exp_kick.size() == 0) check("unexpected_kick", ctrl_enable, 0);
        else begin
          ek = exp_kick.pop_front();
          check("kick_cfg", {layer_idx, cfg_now}, ek);
        end
        kick_cfg = cfg_now; running = 1;
      end else if (running) begin
        check("cfg_stable", cfg_now, kick_cfg);
      end
      if (ctrl_endsignal) running = 0;
      if (done) begin
        check("done_pulse", prev_done, 0);
        done_seen = 1;
      end
      if (prev_busy && !busy) begin
        if (exp_out.size() == 0) check("unexpected_exit", busy, 1);
        else begin
          eo = exp_out.pop_front();
          check("run_outcome", {done_seen, error}, eo);
        end
        done_seen = 0; running = 0;
      end
      prev_busy = busy; prev_en = ctrl_enable; prev_done = done;
    end
  end

  initial begin
    for (int j = 0; j < MAXL; j++) tbl[j] = '0;
    rst = 1'b1;
    tick(); tick();
    check("reset_state", {busy, done, error, layer_idx, ctrl_enable, size_act,
          size_kernel, stride, number_pc_line, address_read_base}, 0);
    rst = 1'b0;
    tick();

    write_cfg(0, mk(28, 5, 1, 6, 16'h0000));
    do_run(1, 10, -1);

    write_cfg(1, mk(28, 3, 1, 6, 16'h0310));
    write_cfg(2, mk(14, 3, 2, 4, 16'h0620));
    do_run(3, 5, -1);

    write_cfg(0, mk(28, 5, 0, 6, 16'h0000));
    do_run(1, 3, -1);
    write_cfg(0, mk(28, 5, 1, 6, 16'h0000));
    do_run(1, 3, -1);
    write_cfg(1, mk(4, 5, 1, 2, 16'h0100));
    do_run(2, 3, -1);
    write_cfg(1, mk(4, 0, 1, 2, 16'h0100));
    do_run(2, 3, -1);
    write_cfg(1, mk(5, 5, 1, 2, 16'h0100));

    do_run(1, TO + 1, -1);
    do_run(1, TO, -1);

    do_run(0, 0, -1);
    do_run(5, 0, -1);
    do_run(4, 2, -1);
    do_run(7, 0, -1);
    do_run(0, 0, -1);

    for (int r = 0; r < 40; r++) begin
      for (int w = 0; w < 3; w++)
        if ($urandom_range(0, 1) == 1) write_cfg($urandom_range(0, 3), rand_desc());
      do_run(($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 4), 0, -1);
    end

    for (int j = 0; j < 3; j++) write_cfg(j, mk(20 + j, 3, 1, 4, 16'h0100 * j));
    do_run(3, 10, 1);
    do_run(1, 3, -1);

    tick(); tick();
    check("kicks_left", exp_kick.size(), 0);
    check("outcomes_left", exp_out.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
